// File: rtl/pkt_wrr_arbiter_if.sv
// Bundle between the per-port packet/descriptor FIFOs, the shared ingress FIFO pair and the
// configuration/status side of pkt_wrr_arbiter.
interface pkt_wrr_arbiter_if #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned PW    = 2
);
    logic                  cfg_wr;
    logic [4*NPORT-1:0]    cfg_weight;
    logic [134*NPORT-1:0]  in_pkt_q;
    logic [NPORT-1:0]      in_pkt_rd;
    logic [12*NPORT-1:0]   in_valid_q;
    logic [NPORT-1:0]      in_valid_empty;
    logic [NPORT-1:0]      in_valid_rd;
    logic                  out_pkt_wr;
    logic [133:0]          out_pkt;
    logic                  in_pkt_almostfull;
    logic                  out_valid_wr;
    logic                  out_valid;
    logic [31:0]           pkt_send_count;
    logic [PW-1:0]         cur_port;
    logic                  err_overlong;
    logic                  err_clr;

    modport slave (
        input  cfg_wr, cfg_weight, in_pkt_q, in_valid_q, in_valid_empty, in_pkt_almostfull,
               err_clr,
        output in_pkt_rd, in_valid_rd, out_pkt_wr, out_pkt, out_valid_wr, out_valid,
               pkt_send_count, cur_port, err_overlong
    );

    modport master (
        output cfg_wr, cfg_weight, in_pkt_q, in_valid_q, in_valid_empty, in_pkt_almostfull,
               err_clr,
        input  in_pkt_rd, in_valid_rd, out_pkt_wr, out_pkt, out_valid_wr, out_valid,
               pkt_send_count, cur_port, err_overlong
    );
endinterface

// File: rtl/pkt_wrr_arbiter.sv
// Packet-granular weighted round-robin arbiter: merges NPORT packet/descriptor FIFO pairs into
// one ingress FIFO pair, stamping length and source port into each head word.
module pkt_wrr_arbiter #(
    parameter int unsigned NPORT      = 4,
    parameter int unsigned PW         = 2,
    parameter int unsigned MAX_WORDS  = 96,
    parameter logic [3:0]  DEF_WEIGHT = 4'd1
) (
    input logic              clk,
    input logic              reset,
    pkt_wrr_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StReload, StXfer} state_e;

    state_e        state_q, state_d;
    logic [3:0]    weight_q [NPORT];
    logic [3:0]    credit_q [NPORT];
    logic [PW-1:0] rr_q;
    logic [PW-1:0] cur_port_q;
    logic [10:0]   len_q;
    logic [CW-1:0] word_cnt_q;
    logic [133:0]  out_pkt_q;
    logic          out_pkt_wr_q;
    logic          out_valid_wr_q;
    logic          err_q;
    logic [31:0]   send_cnt_q;

    logic [133:0]     head_w [NPORT];
    logic [10:0]      desc_len [NPORT];
    logic [NPORT-1:0] eligible;
    logic [NPORT-1:0] unused_desc_msb;
    logic             found;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    idx;
    logic             grant;
    logic             reload;
    logic             xfer;
    logic [133:0]     cur_word;
    logic [133:0]     word_out;
    logic             is_tail;
    logic             overlong;
    logic             last;

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        assign head_w[i]          = bus.in_pkt_q[134*i +: 134];
        assign desc_len[i]        = bus.in_valid_q[12*i +: 11];
        assign unused_desc_msb[i] = bus.in_valid_q[12*i + 11];
        assign eligible[i]        = !bus.in_valid_empty[i] && (weight_q[i] != 4'd0);
    end

    // First eligible port with credit, scanning from the port after the last grant.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = '0;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            idx = PW'((32'(rr_q) + k) % NPORT);
            if (!found && eligible[idx] && (credit_q[idx] != 4'd0)) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        cur_word = head_w[rr_q];
        is_tail  = (cur_word[133:132] == 2'b10);
        overlong = !is_tail && (word_cnt_q == CW'(MAX_WORDS - 1));
        last     = is_tail || overlong;
        word_out = cur_word;
        if (cur_word[133:132] == 2'b01) begin
            word_out[123:113] = len_q;
            word_out[55:47]   = 9'(rr_q);
        end
        if (overlong) begin
            word_out[133:132] = 2'b10;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant           = 1'b0;
        reload          = 1'b0;
        xfer            = 1'b0;
        bus.in_valid_rd = '0;
        bus.in_pkt_rd   = '0;
        unique case (state_q)
            StIdle: begin
                if (!bus.in_pkt_almostfull && (|eligible)) begin
                    if (found) begin
                        grant                 = 1'b1;
                        bus.in_valid_rd[pick] = 1'b1;
                        state_d               = StXfer;
                    end else begin
                        state_d = StReload;
                    end
                end
            end
            StReload: begin
                reload  = 1'b1;
                state_d = StIdle;
            end
            StXfer: begin
                xfer                = 1'b1;
                bus.in_pkt_rd[rr_q] = 1'b1;
                if (last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            rr_q           <= PW'(NPORT - 1);
            cur_port_q     <= '0;
            len_q          <= '0;
            word_cnt_q     <= '0;
            out_pkt_q      <= '0;
            out_pkt_wr_q   <= 1'b0;
            out_valid_wr_q <= 1'b0;
            err_q          <= 1'b0;
            send_cnt_q     <= '0;
            for (int i = 0; i < NPORT; i++) begin
                weight_q[i] <= DEF_WEIGHT;
                credit_q[i] <= DEF_WEIGHT;
            end
        end else begin
            state_q        <= state_d;
            out_pkt_wr_q   <= xfer;
            out_valid_wr_q <= xfer && last;
            if (xfer) begin
                out_pkt_q  <= word_out;
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            if (xfer && last) begin
                send_cnt_q <= send_cnt_q + 32'd1;
            end
            // A new overlong event outranks a simultaneous clear.
            if (xfer && overlong) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
            if (grant) begin
                rr_q           <= pick;
                cur_port_q     <= pick;
                len_q          <= desc_len[pick];
                word_cnt_q     <= '0;
                credit_q[pick] <= credit_q[pick] - 4'd1;
            end
            if (reload) begin
                for (int i = 0; i < NPORT; i++) begin
                    credit_q[i] <= weight_q[i];
                end
            end
            if (bus.cfg_wr) begin
                for (int i = 0; i < NPORT; i++) begin
                    weight_q[i] <= bus.cfg_weight[4*i +: 4];
                end
            end
        end
    end

    assign bus.out_pkt        = out_pkt_q;
    assign bus.out_pkt_wr     = out_pkt_wr_q;
    assign bus.out_valid_wr   = out_valid_wr_q;
    assign bus.out_valid      = out_valid_wr_q;
    assign bus.pkt_send_count = send_cnt_q;
    assign bus.cur_port       = cur_port_q;
    assign bus.err_overlong   = err_q;
endmodule

// File: tb/tb_pkt_wrr_arbiter.sv
// Scoreboard bench for pkt_wrr_arbiter: emulates the per-port show-ahead FIFOs and predicts the
// weighted round-robin output stream word by word.
module tb_pkt_wrr_arbiter;
    localparam int unsigned NP = 4;
    localparam int unsigned PW = 2;
    localparam int unsigned MW = 8;

    typedef struct {
        logic [133:0] word;
        bit           last;
        bit           head;
        int           port;
        int           gap;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    pkt_wrr_arbiter_if #(.NPORT(NP), .PW(PW)) bus ();

    pkt_wrr_arbiter #(
        .NPORT     (NP),
        .PW        (PW),
        .MAX_WORDS (MW),
        .DEF_WEIGHT(4'd1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [133:0] fifo_w [NP][$];
    logic [11:0]  fifo_d [NP][$];
    logic [133:0] mdl_w [NP][$];
    logic [10:0]  mdl_len [NP][$];
    int           mdl_n [NP][$];
    exp_t         sb [$];
    int           m_w [NP];
    int           m_cr [NP];
    int           m_rr;

    logic [NP-1:0] pop_pkt = '0;
    logic [NP-1:0] pop_val = '0;
    int n_grants = 0, n_pops0 = 0, n_heads = 0, n_writes = 0;
    int cyc = 0, last_tail_cyc = 0, exp_cnt = 0;
    logic [133:0] junk_w;
    logic [11:0]  junk_d;

    task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO emulation: pops requested during a cycle take effect just after its closing edge.
    always @(negedge clk) begin
        #2;
        pop_pkt = bus.in_pkt_rd;
        pop_val = bus.in_valid_rd;
        if (pop_val != '0) n_grants++;
        if (pop_pkt[0]) n_pops0++;
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            if (pop_pkt[i] && fifo_w[i].size() > 0) junk_w = fifo_w[i].pop_front();
            if (pop_val[i] && fifo_d[i].size() > 0) junk_d = fifo_d[i].pop_front();
            bus.in_pkt_q[134*i +: 134] = (fifo_w[i].size() > 0) ? fifo_w[i][0] : '0;
            bus.in_valid_q[12*i +: 12] = (fifo_d[i].size() > 0) ? fifo_d[i][0] : '0;
            bus.in_valid_empty[i]      = (fifo_d[i].size() == 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            exp_cnt = 0;
        end else if (bus.out_pkt_wr) begin
            n_writes++;
            if (sb.size() == 0) begin
                check("unexpected_write", 134'(1), 134'(0));
            end else begin
                e = sb.pop_front();
                check("word", bus.out_pkt, e.word);
                check("valid_wr", 134'(bus.out_valid_wr), 134'(e.last));
                if (e.head) begin
                    n_heads++;
                    check("cur_port", 134'(bus.cur_port), 134'(e.port));
                    if (e.gap >= 0) check("gap", 134'(cyc - last_tail_cyc), 134'(e.gap));
                end
                if (e.last) begin
                    exp_cnt++;
                    check("send_count", 134'(bus.pkt_send_count), 134'(exp_cnt));
                    check("out_valid", 134'(bus.out_valid), 134'(1));
                    last_tail_cyc = cyc;
                end
            end
        end else if (bus.out_valid_wr) begin
            check("stray_valid_wr", 134'(1), 134'(0));
        end
    end

    task automatic add_pkt(input int p, input int n, input logic [10:0] len);
        logic [159:0] r;
        logic [1:0]   tag;
        logic [133:0] w;
        for (int k = 0; k < n; k++) begin
            r   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            tag = (k == 0) ? 2'b01 : ((k == n - 1) ? 2'b10 : 2'b11);
            w   = {tag, r[131:0]};
            fifo_w[p].push_back(w);
            mdl_w[p].push_back(w);
        end
        fifo_d[p].push_back({1'b0, len});
        mdl_len[p].push_back(len);
        mdl_n[p].push_back(n);
    endtask

    // Replays the queued packets through the weighted round-robin rules and fills the scoreboard.
    task automatic predict(input bit chk_gap);
        bit reloaded, first, done, any;
        int g, j, n;
        logic [10:0]  len;
        logic [133:0] w;
        exp_t e;
        reloaded = 0;
        first    = 1;
        for (int iter = 0; iter < 1000; iter++) begin
            g = -1;
            for (int k = 1; k <= int'(NP); k++) begin
                j = (m_rr + k) % int'(NP);
                if (g < 0 && mdl_len[j].size() > 0 && m_w[j] != 0 && m_cr[j] > 0) g = j;
            end
            if (g < 0) begin
                any = 0;
                for (int k = 0; k < int'(NP); k++)
                    if (mdl_len[k].size() > 0 && m_w[k] != 0) any = 1;
                if (!any) break;
                for (int k = 0; k < int'(NP); k++) m_cr[k] = m_w[k];
                reloaded = 1;
                continue;
            end
            m_cr[g]--;
            m_rr = g;
            n    = mdl_n[g].pop_front();
            len  = mdl_len[g].pop_front();
            done = 0;
            for (int k = 0; k < n; k++) begin
                w = mdl_w[g].pop_front();
                if (!done) begin
                    e.head = (k == 0);
                    e.port = g;
                    e.gap  = (k == 0 && !first && chk_gap) ? (reloaded ? 4 : 2) : -1;
                    if (w[133:132] == 2'b01) begin
                        w[123:113] = len;
                        w[55:47]   = 9'(g);
                    end
                    e.last = (w[133:132] == 2'b10) || (k == int'(MW) - 1);
                    if (k == int'(MW) - 1) w[133:132] = 2'b10;
                    e.word = w;
                    sb.push_back(e);
                    done = e.last;
                end
            end
            first    = 0;
            reloaded = 0;
        end
    endtask

    task automatic do_reset();
        reset                 = 1'b1;
        bus.in_pkt_almostfull = 1'b1;
        bus.cfg_wr            = 1'b0;
        bus.err_clr           = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            fifo_w[i].delete();
            fifo_d[i].delete();
            mdl_w[i].delete();
            mdl_len[i].delete();
            mdl_n[i].delete();
            m_w[i]  = 1;
            m_cr[i] = 1;
        end
        sb.delete();
        m_rr  = int'(NP) - 1;
        reset = 1'b0;
    endtask

    task automatic set_weights(input logic [4*NP-1:0] w);
        @(negedge clk);
        bus.cfg_weight = w;
        bus.cfg_wr     = 1'b1;
        @(negedge clk);
        bus.cfg_wr = 1'b0;
        for (int i = 0; i < NP; i++) m_w[i] = int'(w[4*i +: 4]);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #3;
        check("drain", 134'(sb.size()), 134'(0));
    endtask

    task automatic run_batch(input bit chk_gap);
        repeat (2) @(negedge clk);
        predict(chk_gap);
        bus.in_pkt_almostfull = 1'b0;
        wait_drain();
        bus.in_pkt_almostfull = 1'b1;
    endtask

    initial begin
        int g0, h0, p0;
        bus.cfg_wr     = 1'b0;
        bus.cfg_weight = '0;
        bus.err_clr    = 1'b0;
        bus.in_pkt_almostfull = 1'b1;
        do_reset();
        @(negedge clk);
        #3;
        check("rst_pkt_wr", 134'(bus.out_pkt_wr), 134'(0));
        check("rst_valid_wr", 134'(bus.out_valid_wr), 134'(0));
        check("rst_out_pkt", bus.out_pkt, 134'(0));
        check("rst_count", 134'(bus.pkt_send_count), 134'(0));
        check("rst_cur_port", 134'(bus.cur_port), 134'(0));
        check("rst_err", 134'(bus.err_overlong), 134'(0));
        check("rst_pops", 134'({bus.in_pkt_rd, bus.in_valid_rd}), 134'(0));

        // Single 4-word packet on port 1.
        add_pkt(1, 4, 11'd64);
        run_batch(1'b1);
        check("t1_count", 134'(bus.pkt_send_count), 134'(1));

        // Ports 0 and 2, equal weights.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add_pkt(0, 2 + $urandom_range(3), 11'(100 + k));
            add_pkt(2, 2 + $urandom_range(3), 11'(200 + k));
        end
        run_batch(1'b1);
        check("t2_count", 134'(bus.pkt_send_count), 134'(8));

        // Weights 3:1.
        do_reset();
        set_weights({4'd0, 4'd0, 4'd1, 4'd3});
        for (int k = 0; k < 8; k++) begin
            add_pkt(0, 2 + $urandom_range(2), 11'(300 + k));
            add_pkt(1, 2 + $urandom_range(2), 11'(400 + k));
        end
        run_batch(1'b1);

        // Almost-full raised mid-packet holds off the next grant only.
        do_reset();
        add_pkt(0, 5, 11'd80);
        add_pkt(1, 4, 11'd64);
        repeat (2) @(negedge clk);
        predict(1'b0);
        h0 = n_heads;
        bus.in_pkt_almostfull = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #3;
            if (n_heads > h0) break;
        end
        bus.in_pkt_almostfull = 1'b1;
        g0 = n_grants;
        repeat (30) @(negedge clk);
        #3;
        check("af_hold_grants", 134'(n_grants - g0), 134'(0));
        check("af_pending_words", 134'(sb.size()), 134'(4));
        bus.in_pkt_almostfull = 1'b0;
        wait_drain();

        // Overlong packet is cut at MAX_WORDS and flags the sticky error.
        do_reset();
        add_pkt(0, 12, 11'd190);
        run_batch(1'b0);
        check("err_set", 134'(bus.err_overlong), 134'(1));
        check("ovl_count", 134'(bus.pkt_send_count), 134'(1));
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #3;
        check("err_clr", 134'(bus.err_overlong), 134'(0));

        // Reset on the third word of a six-word packet.
        do_reset();
        add_pkt(0, 6, 11'd96);
        repeat (2) @(negedge clk);
        predict(1'b0);
        p0 = n_pops0;
        bus.in_pkt_almostfull = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #3;
            if (n_pops0 - p0 >= 3) break;
        end
        check("mid_pops", 134'(n_pops0 - p0), 134'(3));
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_pkt_wr", 134'(bus.out_pkt_wr), 134'(0));
        check("mid_rst_valid_wr", 134'(bus.out_valid_wr), 134'(0));
        check("mid_rst_pkt_rd", 134'(bus.in_pkt_rd), 134'(0));
        check("mid_rst_valid_rd", 134'(bus.in_valid_rd), 134'(0));
        check("mid_rst_out_pkt", bus.out_pkt, 134'(0));
        check("mid_rst_count", 134'(bus.pkt_send_count), 134'(0));

        // All weights zero: pending packets are never granted.
        do_reset();
        set_weights('0);
        for (int p = 0; p < int'(NP); p++) add_pkt(p, 3, 11'd48);
        bus.in_pkt_almostfull = 1'b0;
        g0 = n_grants;
        h0 = n_writes;
        repeat (40) @(negedge clk);
        #3;
        check("zero_w_grants", 134'(n_grants - g0), 134'(0));
        check("zero_w_writes", 134'(n_writes - h0), 134'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
